// File: rtl/gcd_arbiter.sv
// -----------------------------------------------------------------------------
// gcd_arbiter
//
// Shares one external binary-GCD engine between NREQ requesters using
// round-robin arbitration. The winner's operands are latched onto eng_m/eng_n,
// the engine is started with a one-cycle pulse, and the result is returned to
// the winner together with a one-cycle one-hot ack. Operand pairs containing a
// zero bypass the engine (gcd(0,x) = x).
//
// Optional feature macro: GCD_TIMEOUT_EN
//   When defined, a watchdog counts cycles spent in WAIT. After TO_CYCLES
//   cycles without eng_done the request completes with gcd_out=0 and err=1.
//   When undefined, err is tied low and WAIT waits indefinitely.
//
// Ports:
//   clk        in   1        clock, all state on rising edge
//   rst        in   1        asynchronous active-high reset
//   req        in   NREQ     per-requester request level, held until own ack
//   m_in       in   NREQ*W   flattened operand m, requester i at [i*W +: W]
//   n_in       in   NREQ*W   flattened operand n, same packing
//   ack        out  NREQ     one-hot one-cycle pulse to the served requester
//   gcd_out    out  W        result, valid in the ack cycle, 0 otherwise
//   busy       out  1        high in every state except IDLE
//   err        out  1        high with ack on a timed-out request
//   eng_start  out  1        one-cycle engine start pulse
//   eng_m      out  W        latched operand m for the engine
//   eng_n      out  W        latched operand n for the engine
//   eng_done   in   1        engine result valid (sampled only in WAIT)
//   eng_gcd    in   W        engine result
// -----------------------------------------------------------------------------
module gcd_arbiter #(
    parameter int NREQ      = 4,
    parameter int W         = 16,
    parameter int TO_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] m_in,
    input  logic [NREQ*W-1:0] n_in,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      gcd_out,
    output logic              busy,
    output logic              err,
    output logic              eng_start,
    output logic [W-1:0]      eng_m,
    output logic [W-1:0]      eng_n,
    input  logic              eng_done,
    input  logic [W-1:0]      eng_gcd
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // Elaboration-time parameter sanity check.
    if ((NREQ < 2) || (NREQ > 8) || (TO_CYCLES < 1)) begin : g_param_check
        $error("gcd_arbiter: NREQ must be 2..8 and TO_CYCLES >= 1");
    end

    logic [1:0]      state_q,     state_d;
    logic [IW-1:0]   ptr_q,       ptr_d;
    logic [IW-1:0]   win_q,       win_d;
    logic [W-1:0]    eng_m_q,     eng_m_d;
    logic [W-1:0]    eng_n_q,     eng_n_d;
    logic [NREQ-1:0] ack_q,       ack_d;
    logic [W-1:0]    gcd_q,       gcd_d;
    logic            busy_q,      busy_d;
    logic            eng_start_q, eng_start_d;
    logic            err_d;

    logic            grant_found_s;
    logic [IW-1:0]   grant_idx_s;
    logic [W-1:0]    grant_m_s;
    logic [W-1:0]    grant_n_s;

`ifdef GCD_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_q;
`endif

    // Round-robin search: first set req bit starting at ptr_q, wrapping at NREQ.
    always_comb begin
        int idx_v;
        idx_v         = 0;
        grant_found_s = 1'b0;
        grant_idx_s   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            idx_v = int'(ptr_q) + k;
            idx_v = (idx_v >= NREQ) ? (idx_v - NREQ) : idx_v;
            if (!grant_found_s && req[IW'(idx_v)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = IW'(idx_v);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    assign grant_m_s = m_in[grant_idx_s*W +: W];
    assign grant_n_s = n_in[grant_idx_s*W +: W];

    // FSM next-state and next-output logic; outputs are registered from the
    // next state so each output is high for exactly the cycle of its state.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        eng_m_d     = eng_m_q;
        eng_n_d     = eng_n_q;
        eng_start_d = 1'b0;
        gcd_d       = '0;
        err_d       = 1'b0;
`ifdef GCD_TIMEOUT_EN
        timer_d     = timer_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_found_s) begin
                    win_d       = grant_idx_s;
                    eng_m_d     = grant_m_s;
                    eng_n_d     = grant_n_s;
                    state_d     = S_LOAD;
                    // The start pulse coincides with LOAD, so decide it from
                    // the operands being latched now.
                    eng_start_d = (grant_m_s != '0) && (grant_n_s != '0);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if ((eng_m_q == '0) || (eng_n_q == '0)) begin
                    // gcd(0,x) = x and gcd(0,0) = 0, both equal to the OR.
                    gcd_d   = eng_m_q | eng_n_q;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
`ifdef GCD_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            S_WAIT: begin
                if (eng_done) begin
                    gcd_d   = eng_gcd;
                    state_d = S_RESP;
                end else begin
`ifdef GCD_TIMEOUT_EN
                    if (timer_q == TW'(TO_CYCLES - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_RESP: begin
                ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : (win_q + IW'(1));
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ack_d  = (state_d == S_RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << win_d) : '0;
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            eng_m_q     <= '0;
            eng_n_q     <= '0;
            ack_q       <= '0;
            gcd_q       <= '0;
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            eng_m_q     <= eng_m_d;
            eng_n_q     <= eng_n_d;
            ack_q       <= ack_d;
            gcd_q       <= gcd_d;
            busy_q      <= busy_d;
            eng_start_q <= eng_start_d;
        end
    end

`ifdef GCD_TIMEOUT_EN
    // Watchdog timer and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ack       = ack_q;
    assign gcd_out   = gcd_q;
    assign busy      = busy_q;
    assign eng_start = eng_start_q;
    assign eng_m     = eng_m_q;
    assign eng_n     = eng_n_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
module tb_gcd_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int TO   = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] m_in;
    logic [NREQ*W-1:0] n_in;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      gcd_out;
    logic              busy;
    logic              err;
    logic              eng_start;
    logic [W-1:0]      eng_m;
    logic [W-1:0]      eng_n;
    logic              eng_done = 1'b0;
    logic [W-1:0]      eng_gcd  = '0;

    gcd_arbiter #(.NREQ(NREQ), .W(W), .TO_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .m_in      (m_in),
        .n_in      (n_in),
        .ack       (ack),
        .gcd_out   (gcd_out),
        .busy      (busy),
        .err       (err),
        .eng_start (eng_start),
        .eng_m     (eng_m),
        .eng_n     (eng_n),
        .eng_done  (eng_done),
        .eng_gcd   (eng_gcd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [W-1:0] g;
        logic       e;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Engine model state
    int           start_cnt = 0;
    int           eng_lat   = 20;
    bit           hang      = 1'b0;
    bit           pend      = 1'b0;
    int           cnt       = 0;
    logic [W-1:0] em        = '0;
    logic [W-1:0] en        = '0;

    function automatic logic [W-1:0] euclid(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
        logic [W-1:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != '0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // GCD engine model: answers eng_latency cycles after a start pulse.
    always @(posedge clk) begin
        if (rst) begin
            pend     <= 1'b0;
            eng_done <= 1'b0;
            cnt      <= 0;
        end else begin
            eng_done <= 1'b0;
            if (eng_start) begin
                pend      <= !hang;
                cnt       <= eng_lat;
                em        <= eng_m;
                en        <= eng_n;
                start_cnt <= start_cnt + 1;
            end else if (pend) begin
                if (cnt <= 1) begin
                    eng_done <= 1'b1;
                    eng_gcd  <= euclid(em, en);
                    pend     <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_op(input int i, input int m, input int n);
        m_in[i*W +: W] = W'(m);
        n_in[i*W +: W] = W'(n);
    endtask

    // Wait (bounded) for an ack, then pop the scoreboard and compare.
    task automatic wait_ack(input bit drop, output int waited);
        exp_t e;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while ((ack == '0) && (waited < 400));
        chk("ack_seen", 32'(ack != '0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ack_onehot", 32'(ack), 32'(1) << e.idx);
            chk("gcd_out", 32'(gcd_out), 32'(e.g));
            chk("err", 32'(err), 32'(e.e));
            if (drop) req[e.idx] = 1'b0;
        end else begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_gcd"}, 32'(gcd_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_start"}, 32'(eng_start), 32'd0);
        chk({tag, "_engm"}, 32'(eng_m), 32'd0);
        chk({tag, "_engn"}, 32'(eng_n), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int s0;
        int bm[3] = '{0, 17, 0};
        int bn[3] = '{35, 0, 0};
        int bg[3] = '{35, 17, 0};

        rst  = 1'b1;
        req  = '0;
        m_in = '0;
        n_in = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Single request through the engine
        set_op(0, 2322, 654);
        eng_lat = 20;
        s0 = start_cnt;
        sb.push_back('{idx: 0, g: 16'd6, e: 1'b0});
        req[0] = 1'b1;
        wait_ack(1'b1, w);
        chk("single_starts", 32'(start_cnt - s0), 32'd1);
        chk("single_engm", 32'(em), 32'd2322);
        chk("single_engn", 32'(en), 32'd654);
        @(negedge clk);
        chk("single_busy_fall", 32'(busy), 32'd0);

        // Bypass: ack lands in the third cycle counting the request cycle,
        // i.e. two negedges after the request is driven in IDLE.
        for (int i = 0; i < 3; i++) begin
            set_op(2, bm[i], bn[i]);
            s0 = start_cnt;
            sb.push_back('{idx: 2, g: W'(bg[i]), e: 1'b0});
            req[2] = 1'b1;
            wait_ack(1'b1, w);
            chk("bypass_latency", 32'(w), 32'd2);
            chk("bypass_no_start", 32'(start_cnt - s0), 32'd0);
            @(negedge clk);
        end

        // Reset asserted between clock edges while waiting on the engine
        set_op(0, 48, 18);
        eng_lat = 50;
        req[0] = 1'b1;
        repeat (8) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Round-robin with all requests held; pointer restarts at 0
        set_op(0, 48, 18);
        set_op(1, 35, 21);
        set_op(2, 17, 5);
        set_op(3, 100, 75);
        eng_lat = 3;
        sb.push_back('{idx: 0, g: 16'd6,  e: 1'b0});
        sb.push_back('{idx: 1, g: 16'd7,  e: 1'b0});
        sb.push_back('{idx: 2, g: 16'd1,  e: 1'b0});
        sb.push_back('{idx: 3, g: 16'd25, e: 1'b0});
        sb.push_back('{idx: 0, g: 16'd6,  e: 1'b0});
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(1'b0, w);
        end
        req = '0;
        @(negedge clk);
        chk("rr_idle", 32'(busy), 32'd0);

        // Withdrawal of req[1] during WAIT; req[3] is served next
        set_op(1, 35, 21);
        set_op(3, 100, 75);
        eng_lat = 20;
        sb.push_back('{idx: 1, g: 16'd7,  e: 1'b0});
        sb.push_back('{idx: 3, g: 16'd25, e: 1'b0});
        req = 4'b1010;
        repeat (5) @(negedge clk);
        req[1] = 1'b0;
        wait_ack(1'b1, w);
        wait_ack(1'b1, w);
        @(negedge clk);
        chk("withdraw_idle", 32'(busy), 32'd0);

`ifdef GCD_TIMEOUT_EN
        // Stuck engine: ack+err 64 cycles after entering WAIT. Counting from
        // the LOAD-cycle negedge, WAIT occupies the next 64 negedges, so the
        // ack is seen on the 65th.
        hang = 1'b1;
        set_op(0, 48, 18);
        req[0] = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!eng_start && (w < 20));
        chk("to_start_seen", 32'(eng_start), 32'd1);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while ((ack == '0) && (w < 200));
        chk("to_latency", 32'(w), 32'd65);
        chk("to_ack", 32'(ack), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        chk("to_gcd", 32'(gcd_out), 32'd0);
        req[0] = 1'b0;
        hang = 1'b0;
        @(negedge clk);
        sb.push_back('{idx: 0, g: 16'd6, e: 1'b0});
        req[0] = 1'b1;
        wait_ack(1'b1, w);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
